mem_ctrl_arbiter: RTL and testbench
===================================

Name: mem_ctrl_arbiter

Overview:
- Sequences the 256x32 level-sensitive main-memory RAM and shares it between two requesters: port 0 (instruction fetch) and port 1 (load/store datapath).
- Latches one request at a time and drives the RAM in three phases: setup with chip-select low, strobe with chip-select high, then release.
- Captures read data and returns a one-cycle ack to the granted requester.
- Sits between the CPU control unit and the RAM; it is the only driver of RAM chipSelect/writeEnable.

Parameters:
- ADDR_W, 9, address width on all ports.
- DATA_W, 32, data width.
- DEPTH, 256, number of implemented RAM words; addresses >= DEPTH are out of range.
- STROBE_CYCLES, 1, cycles ram_cs is held high (legal range 1..4).

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  synchronous active-low reset.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data, registered.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- ram_cs  out  1  RAM chipSelect.
- ram_we  out  1  RAM writeEnable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM dataIn.
- ram_dout  in  DATA_W  RAM dataOut.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: clock and clear_n are the single clock and a synchronous active-low reset. clear_n low at a rising edge forces:
  - state to IDLE;
  - ram_cs, ram_we, busy, p0_ack, p1_ack to 0;
  - ram_addr, ram_din, p0_rdata, p1_rdata to 0;
  - the round-robin pointer (if enabled) to "last = port 1".
- Reset mid-operation: a transaction in SETUP is abandoned with no RAM access. A write whose STROBE was entered is considered performed. No ack is issued for any aborted transaction.
- States and transitions:
  - IDLE: if any req is high, grant per arbitration; latch we/addr/wdata of the winner into ram_we/ram_addr/ram_din. ram_we is latched as 0 for reads. Go to SETUP.
  - SETUP: ram_cs=0, address/data/we stable. Go to STROBE.
  - STROBE: ram_cs=1 for STROBE_CYCLES cycles, counted by an internal counter. On the last STROBE edge, for a read, the granted port's rdata <= ram_dout. Go to DONE.
  - DONE: ram_cs=0, ram_we still held. Granted port's ack=1 for exactly this cycle. Go to IDLE.
- Leaving IDLE: ram_we returns to 0 in IDLE. Ordering is always cs falls before we changes.
- Latency: req sampled at edge N gives ack high during cycle N+2+STROBE_CYCLES (N+3 by default). Maximum throughput is one transaction per 3+STROBE_CYCLES cycles.
- Requester inputs: sampled only at the IDLE grant edge. Changes after grant are ignored. A req dropped before ack still completes and acks. A req still high in the cycle after ack is a new request.
- rdata: each port's rdata holds its value until that port's next read completes. Writes leave rdata unchanged.
- Out of range (addr >= DEPTH): the sequence runs normally but ram_cs stays 0 throughout. A read returns 0; a write is dropped; ack is still issued.
- Simultaneous requests: fixed priority, port 1 wins; the loser waits in IDLE arbitration. The grant is latched and cannot change mid-transaction.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous requests, the port not granted last wins. The pointer updates at each grant and resets to "last = port 1", so port 0 wins the first tie.
- Undefined: fixed priority, port 1 always wins ties. No pointer register exists.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, DONE);
  - ADDR_W/DATA_W/DEPTH defaults;
  - port index constants PORT_FETCH=0, PORT_DATA=1.
- One sub-module, mem_arb_grant: combinational winner selection plus the round-robin pointer register, with the pointer present only under the macro.

Test Plan:
- Reset: hold clear_n=0 for 2 cycles during a STROBE -> next cycle state IDLE, ram_cs=0, ram_we=0, acks=0, rdatas=0, busy=0.
- Single read: preload addr 0x005=0xDEADBEEF; p0 reads 0x005 at edge 10 -> ram_cs high cycle 12 only, p0_ack pulse cycle 13, p0_rdata=0xDEADBEEF.
- Write then read: p1 writes 0x0A0=0x12345678, then reads 0x0A0 -> second p1_rdata=0x12345678; ram_we rises before ram_cs and falls after ram_cs falls.
- Tie: p0 and p1 request together -> p1 acked first, p0 acked 4 cycles later. With MEM_ARB_ROUND_ROBIN_EN, p0 is acked first, and a second tie goes to p1.
- Out of range: p0 reads 0x1FF -> ram_cs never rises, p0_ack at +3, p0_rdata=0. A write to 0x100 leaves RAM[0x000] unchanged.
- STROBE_CYCLES=3: read latency 5 cycles, ram_cs high exactly 3 consecutive cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// State encodings are kept as plain constants so legacy logic can match them.
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 256;

  localparam int NUM_PORTS  = 2;
  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    STROBE = ST_STROBE,
    DONE   = ST_DONE
  } state_e;

  function automatic logic in_range(input logic [31:0] addr, input int depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection between the fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN adds a last-granted pointer; otherwise the data port wins ties.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 take,
`endif
  input  logic [NUM_PORTS-1:0] req,
  output logic                 any,
  output logic                 win
);

  assign any = |req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last;

  // Reset value points at the data port so the fetch port wins the first tie.
  always_ff @(posedge clock) begin
    if (!clear_n)         last <= 1'b1;
    else if (take && any) last <= win;
  end

  assign win = (&req) ? ~last : req[PORT_DATA];
`else
  assign win = req[PORT_DATA];
`endif

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Sequences the level-sensitive main RAM (setup / strobe / release) for two requesters.
// Tie-breaking is fixed priority unless MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_ctrl_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam int               CNT_W       = 2;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

  state_e                           state;
  logic                             gnt, in_rng, any, win;
  logic [CNT_W-1:0]                 scnt;
  logic [NUM_PORTS-1:0]             req_v, we_v, ack_q;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v, rdata_q;

  assign req_v   = {p1_req, p0_req};
  assign we_v    = {p1_we, p0_we};
  assign addr_v  = {p1_addr, p0_addr};
  assign wdata_v = {p1_wdata, p0_wdata};

  mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clock   (clock),
    .clear_n (clear_n),
    .take    (state == IDLE),
`endif
    .req     (req_v),
    .any     (any),
    .win     (win)
  );

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      in_rng   <= 1'b0;
      scnt     <= '0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE: begin
          ram_we <= 1'b0;
          if (any) begin
            gnt      <= win;
            ram_we   <= we_v[win];
            ram_addr <= addr_v[win];
            ram_din  <= wdata_v[win];
            in_rng   <= in_range(32'(addr_v[win]), DEPTH);
            state    <= SETUP;
          end
        end
        SETUP: begin
          // Out-of-range accesses walk the same sequence with chip-select held low.
          ram_cs <= in_rng;
          scnt   <= '0;
          state  <= STROBE;
        end
        STROBE: begin
          if (scnt == STROBE_LAST) begin
            ram_cs     <= 1'b0;
            if (!ram_we) rdata_q[gnt] <= in_rng ? ram_dout : '0;
            ack_q[gnt] <= 1'b1;
            state      <= DONE;
          end else begin
            scnt <= scnt + CNT_W'(1);
          end
        end
        DONE: begin
          // we drops only here, one cycle after cs has already fallen.
          ram_we <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_ack   = ack_q[PORT_FETCH];
  assign p1_ack   = ack_q[PORT_DATA];
  assign p0_rdata = rdata_q[PORT_FETCH];
  assign p1_rdata = rdata_q[PORT_DATA];
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench for mem_ctrl_arbiter: one instance with a single strobe cycle, one with three.
// Both share requester inputs; a selector chooses which instance the checks observe.
module tb_mem_ctrl_arbiter;
  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [8:0]  p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;

  logic        a_p0_ack, a_p1_ack, a_cs, a_we, a_busy;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_din, a_dout;
  logic [8:0]  a_addr;
  logic        b_p0_ack, b_p1_ack, b_cs, b_we, b_busy;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_din, b_dout;
  logic [8:0]  b_addr;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  int n_cmp = 0, n_err = 0;
  bit sel3 = 1'b0;

  always #5 clock = ~clock;

  mem_ctrl_arbiter dut (
    .clock(clock), .clear_n(clear_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .ram_cs(a_cs), .ram_we(a_we), .ram_addr(a_addr), .ram_din(a_din),
    .ram_dout(a_dout), .busy(a_busy));

  mem_ctrl_arbiter #(.STROBE_CYCLES(3)) dut3 (
    .clock(clock), .clear_n(clear_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .ram_cs(b_cs), .ram_we(b_we), .ram_addr(b_addr), .ram_din(b_din),
    .ram_dout(b_dout), .busy(b_busy));

  // Level-sensitive RAM models; only 8 address bits decode, so 0x100 aliases 0x000.
  assign a_dout = mem_a[a_addr[7:0]];
  assign b_dout = mem_b[b_addr[7:0]];
  always @(posedge clock) if (a_cs && a_we) mem_a[a_addr[7:0]] <= a_din;
  always @(posedge clock) if (b_cs && b_we) mem_b[b_addr[7:0]] <= b_din;

  wire        o_p0_ack   = sel3 ? b_p0_ack   : a_p0_ack;
  wire        o_p1_ack   = sel3 ? b_p1_ack   : a_p1_ack;
  wire [31:0] o_p0_rdata = sel3 ? b_p0_rdata : a_p0_rdata;
  wire [31:0] o_p1_rdata = sel3 ? b_p1_rdata : a_p1_rdata;
  wire        o_cs       = sel3 ? b_cs       : a_cs;
  wire        o_we       = sel3 ? b_we       : a_we;
  wire        o_busy     = sel3 ? b_busy     : a_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction from idle; expects ack at exp_lat and exp_cs strobe cycles starting at cycle 2.
  task automatic run(input bit port, input logic we, input logic [8:0] a, input logic [31:0] d,
                     input int exp_lat, input int exp_cs, input string tag);
    int ack_at = 0, cs_n = 0, cs_first = 0;
    logic we_pre = 1'b0, we_post = 1'b0;
    if (port) begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
    else      begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
    for (int c = 1; c <= 12 && ack_at == 0; c++) begin
      @(negedge clock);
      if (c == 1) we_pre = o_we;
      if (o_cs) begin cs_n++; if (cs_first == 0) cs_first = c; end
      if (port ? o_p1_ack : o_p0_ack) begin ack_at = c; we_post = o_we; end
    end
    p0_req = 0; p1_req = 0;
    chk({tag, "_lat"}, ack_at, exp_lat);
    chk({tag, "_cscnt"}, cs_n, exp_cs);
    if (exp_cs != 0) chk({tag, "_csfirst"}, cs_first, 2);
    chk({tag, "_we_setup"}, we_pre, we);
    chk({tag, "_we_done"}, we_post, we);
    @(negedge clock);
    chk({tag, "_ackoff"}, {o_p0_ack, o_p1_ack}, 2'b00);
    chk({tag, "_idle"}, {o_busy, o_cs, o_we}, 3'b000);
  endtask

  // Both ports read at once; loser must follow four cycles after the winner.
  task automatic tie(input bit exp_first, input string tag);
    int a0 = 0, a1 = 0;
    p0_req = 1; p0_we = 0; p0_addr = 9'h005;
    p1_req = 1; p1_we = 0; p1_addr = 9'h0A0;
    for (int c = 1; c <= 20 && (a0 == 0 || a1 == 0); c++) begin
      @(negedge clock);
      if (o_p0_ack && a0 == 0) begin a0 = c; p0_req = 0; end
      if (o_p1_ack && a1 == 0) begin a1 = c; p1_req = 0; end
    end
    p0_req = 0; p1_req = 0;
    chk({tag, "_first"}, exp_first ? a1 : a0, 3);
    chk({tag, "_second"}, exp_first ? a0 : a1, 7);
    chk({tag, "_p0rd"}, o_p0_rdata, 32'hDEADBEEF);
    chk({tag, "_p1rd"}, o_p1_rdata, 32'h12345678);
    @(negedge clock);
    chk({tag, "_idle"}, o_busy, 1'b0);
  endtask

  // Start a p1 write, let it reach `depth` cycles in, then hold reset for two cycles.
  task automatic reset_mid(input int depth, input logic [8:0] a, input logic [31:0] d, input string tag);
    bit saw_ack = 0;
    p1_req = 1; p1_we = 1; p1_addr = a; p1_wdata = d;
    for (int c = 1; c <= depth; c++) begin
      @(negedge clock);
      saw_ack |= o_p1_ack;
    end
    chk({tag, "_cs_at_reset"}, o_cs, depth == 2);
    clear_n = 0; p1_req = 0; p1_we = 0;
    repeat (2) begin @(negedge clock); saw_ack |= o_p1_ack; end
    clear_n = 1;
    @(negedge clock);
    saw_ack |= o_p1_ack;
    chk({tag, "_noack"}, saw_ack, 1'b0);
    chk({tag, "_ctl"}, {o_busy, o_cs, o_we, o_p0_ack, o_p1_ack}, 5'b0);
    chk({tag, "_rdata"}, o_p0_rdata | o_p1_rdata, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ctl", {a_busy, a_cs, a_we, a_p0_ack, a_p1_ack}, 5'b0);
    chk("rst_rdata", a_p0_rdata | a_p1_rdata, 32'h0);
    chk("rst_addr", {23'd0, a_addr}, 32'h0);
    chk("rst_din", a_din, 32'h0);
    clear_n = 1;
    @(negedge clock);

    run(1, 1, 9'h005, 32'hDEADBEEF, 3, 1, "w005");
    run(1, 1, 9'h0FF, 32'hCAFEF00D, 3, 1, "w0ff");
    run(1, 1, 9'h000, 32'h0BADF00D, 3, 1, "w000");
    run(0, 0, 9'h005, 32'h0,        3, 1, "r005");
    chk("r005_data", a_p0_rdata, 32'hDEADBEEF);
    chk("wr_keeps_p1rd", a_p1_rdata, 32'h0);
    run(1, 1, 9'h0A0, 32'h12345678, 3, 1, "w0a0");
    run(1, 0, 9'h0A0, 32'h0,        3, 1, "r0a0");
    chk("r0a0_data", a_p1_rdata, 32'h12345678);
    chk("p0rd_held", a_p0_rdata, 32'hDEADBEEF);

    run(0, 0, 9'h1FF, 32'h0,        3, 0, "oor_rd");
    chk("oor_rd_data", a_p0_rdata, 32'h0);
    run(1, 1, 9'h100, 32'hFFFFFFFF, 3, 0, "oor_wr");
    chk("oor_wr_alias", mem_a[0], 32'h0BADF00D);

    // Inputs changed and req dropped after grant: the latched read of 0x0A0 still completes.
    begin
      int ack_at = 0;
      p0_req = 1; p0_we = 0; p0_addr = 9'h0A0;
      @(negedge clock);
      p0_req = 0; p0_we = 1; p0_addr = 9'h005; p0_wdata = 32'h0;
      for (int c = 2; c <= 10 && ack_at == 0; c++) begin
        @(negedge clock);
        if (a_p0_ack) ack_at = c;
      end
      p0_we = 0;
      chk("late_lat", ack_at, 3);
      chk("late_data", a_p0_rdata, 32'h12345678);
      chk("late_nowrite", mem_a[5], 32'hDEADBEEF);
      @(negedge clock);
    end

    run(1, 0, 9'h0A0, 32'h0, 3, 1, "pre_tie");
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie(1'b0, "tie1");
`else
    tie(1'b1, "tie1");
`endif
    run(0, 0, 9'h0FF, 32'h0, 3, 1, "mid_tie");
    chk("mid_tie_data", a_p0_rdata, 32'hCAFEF00D);
    tie(1'b1, "tie2");

    reset_mid(1, 9'h005, 32'h0, "rst_setup");
    chk("rst_setup_nowr", mem_a[5], 32'hDEADBEEF);
    reset_mid(2, 9'h0A0, 32'h55555555, "rst_strobe");
    chk("rst_strobe_wr", mem_a[8'hA0], 32'h55555555);

    sel3 = 1'b1;
    chk("s3_rst_rdata", o_p0_rdata | o_p1_rdata, 32'h0);
    run(1, 1, 9'h010, 32'hA5A5A5A5, 5, 3, "s3_w");
    run(0, 0, 9'h010, 32'h0,        5, 3, "s3_r");
    chk("s3_r_data", o_p0_rdata, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
